// File: rtl/alu_operand_loader.sv
// Operand feeder for the Alu block: takes a command, assembles A and B from a stream
// of narrow words (LS word first), then waits the ALU latency and flags the result cycle.
module alu_operand_loader #(
    parameter int unsigned DATA_WIDTH  = 1024,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_opcode,
    input  logic                  cmd_b_short,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic [2:0]            opcode,
    output logic [DATA_WIDTH-1:0] A_in,
    output logic [DATA_WIDTH-1:0] B_in,
    output logic                  alu_sample,
    output logic                  busy
);

    localparam int unsigned BEATS = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LatW  = $clog2(ALU_LATENCY + 1);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
    localparam logic [LatW-1:0]  LatLoad  = LatW'(ALU_LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StWait
    } state_e;

    state_e                  state_q;
    logic [BeatW-1:0]        beat_cnt_q;
    logic [LatW-1:0]         lat_cnt_q;
    logic                    b_short_q;
    logic [2:0]              opcode_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;

    logic                    a_last;
    logic                    b_last;

    assign a_last = (beat_cnt_q == LastBeat);
    // A short B operand is a single word, so its only beat is also its last.
    assign b_last = b_short_q ? (beat_cnt_q == '0) : (beat_cnt_q == LastBeat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
            b_short_q  <= 1'b0;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        opcode_q   <= cmd_opcode;
                        b_short_q  <= cmd_b_short;
                        beat_cnt_q <= '0;
                        if (cmd_b_short) begin
                            b_q <= '0;
                        end
                        state_q <= StLoadA;
                    end
                end
                StLoadA: begin
                    if (wr_valid) begin
                        a_q[beat_cnt_q*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                        if (a_last) begin
                            beat_cnt_q <= '0;
                            state_q    <= StLoadB;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                StLoadB: begin
                    if (wr_valid) begin
                        b_q[beat_cnt_q*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                        if (b_last) begin
                            lat_cnt_q <= LatLoad;
                            state_q   <= StWait;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (lat_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign wr_ready   = (state_q == StLoadA) || (state_q == StLoadB);
    assign busy       = (state_q != StIdle);
    assign alu_sample = (state_q == StWait) && (lat_cnt_q == '0);

    assign opcode = opcode_q;
    assign A_in   = a_q;
    assign B_in   = b_q;

    // The two handshakes are never open at once, and a sample only happens mid-command.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(cmd_ready && wr_ready));
            assert (!alu_sample || busy);
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised bench for alu_operand_loader: a word-list model predicts A/B contents,
// the sample cycle and the return to idle for each command.
module tb_alu_operand_loader;

    localparam int unsigned Dw    = 1024;
    localparam int unsigned Ww    = 32;
    localparam int unsigned Beats = Dw / Ww;
    localparam int unsigned Lat   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode = '0;
    logic          cmd_b_short = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [Ww-1:0] wr_data = '0;
    logic [2:0]    opcode;
    logic [Dw-1:0] A_in;
    logic [Dw-1:0] B_in;
    logic          alu_sample;
    logic          busy;

    alu_operand_loader #(
        .DATA_WIDTH (Dw),
        .WORD_WIDTH (Ww),
        .ALU_LATENCY(Lat)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_b_short(cmd_b_short),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .opcode     (opcode),
        .A_in       (A_in),
        .B_in       (B_in),
        .alu_sample (alu_sample),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [Ww-1:0] wa[Beats];
    logic [Ww-1:0] wb[Beats];

    task automatic check_eq(input string tag, input logic [Dw-1:0] got,
                            input logic [Dw-1:0] exp);
        int w;
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            w = 0;
            for (int i = Beats - 1; i >= 0; i--) begin
                if (got[i*Ww +: Ww] !== exp[i*Ww +: Ww]) w = i;
            end
            $display("FAIL %s: word %0d got %h want %h", tag, w, got[w*Ww +: Ww],
                     exp[w*Ww +: Ww]);
        end
    endtask

    function automatic logic [Dw-1:0] model_a();
        logic [Dw-1:0] r = '0;
        for (int i = 0; i < Beats; i++) r = r | ({{(Dw-Ww){1'b0}}, wa[i]} << (i * Ww));
        return r;
    endfunction

    // Short B keeps only word 0; everything above it reads zero.
    function automatic logic [Dw-1:0] model_b(input bit short_b);
        logic [Dw-1:0] r = '0;
        int n = short_b ? 1 : Beats;
        for (int i = 0; i < n; i++) r = r | ({{(Dw-Ww){1'b0}}, wb[i]} << (i * Ww));
        return r;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < Beats; i++) begin
            wa[i] = $urandom;
            wb[i] = $urandom;
        end
    endtask

    task automatic fill_directed(input logic [Ww-1:0] a0, input logic [Ww-1:0] bw);
        for (int i = 0; i < Beats; i++) begin
            wa[i] = (i == 0) ? a0 : '0;
            wb[i] = bw;
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, "_A"}, A_in, '0);
        check_eq({where, "_B"}, B_in, '0);
        check_eq({where, "_opcode"}, opcode, '0);
        check_eq({where, "_sample"}, alu_sample, 0);
        check_eq({where, "_busy"}, busy, 0);
        check_eq({where, "_wr_ready"}, wr_ready, 0);
        check_eq({where, "_cmd_ready"}, cmd_ready, 1);
    endtask

    task automatic reset_and_settle();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(posedge clk);
        #1 check_reset_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_sample", alu_sample, 0);
            check_eq("post_rst_busy", busy, 0);
        end
    endtask

    // Entered and left at a negedge with the DUT idle (or about to be idle).
    task automatic run_cmd(input logic [2:0] op, input bit short_b, input bit stall,
                           input int rst_at, input bit chain, input logic [2:0] next_op,
                           input bit next_short);
        int total;
        int idx;
        int guard;
        int last;
        int samples;
        int scyc;
        logic [Dw-1:0] ea;
        logic [Dw-1:0] eb;

        ea = model_a();
        eb = model_b(short_b);
        check_eq("idle_cmd_ready", cmd_ready, 1);
        check_eq("idle_wr_ready", wr_ready, 0);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_b_short = short_b;
        wr_valid    = stall;
        wr_data     = 32'hDEAD_BEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("busy_after_cmd", busy, 1);

        total = Beats + (short_b ? 1 : Beats);
        idx   = 0;
        guard = 0;
        last  = 0;
        while (idx < total && guard < 4000) begin
            if (rst_at >= 0 && idx == rst_at) begin
                reset_and_settle();
                return;
            end
            wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = !wr_valid ? Ww'($urandom) : (idx < Beats) ? wa[idx] : wb[idx - Beats];
            #1;
            if (wr_valid && wr_ready) begin
                last = cyc;
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b0;
        if (idx < total) begin
            check_eq("load_timeout", idx, total);
            return;
        end

        samples = 0;
        scyc    = -1;
        guard   = 0;
        while (busy && guard < Lat + 10) begin
            if (chain) begin
                cmd_valid   = 1'b1;
                cmd_opcode  = next_op;
                cmd_b_short = next_short;
            end
            check_eq("wait_wr_ready", wr_ready, 0);
            check_eq("wait_opcode", opcode, op);
            if (alu_sample) begin
                samples++;
                scyc = cyc;
                check_eq("sample_A", A_in, ea);
                check_eq("sample_B", B_in, eb);
            end
            @(negedge clk);
            guard++;
        end
        check_eq("sample_count", samples, 1);
        check_eq("sample_cycle", scyc, last + 1 + Lat);
        check_eq("idle_cycle", cyc, scyc + 1);
        check_eq("idle_cmd_ready", cmd_ready, 1);
    endtask

    logic [2:0] r_op[9];
    bit         r_short[9];
    bit         r_stall[9];

    initial begin
        #1 check_reset_outputs("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill_directed(32'hAC, 32'hAC);
        run_cmd(3'd0, 1'b0, 1'b0, -1, 1'b0, 3'd0, 1'b0);
        fill_directed(32'hAD, 32'hAD);
        run_cmd(3'd0, 1'b0, 1'b0, -1, 1'b0, 3'd0, 1'b0);
        fill_directed(32'hED, 32'h1234_5678);
        run_cmd(3'd1, 1'b1, 1'b0, -1, 1'b0, 3'd0, 1'b0);
        // Leave B full of nonzero upper words, then a short B must clear them.
        fill_rand();
        run_cmd(3'd3, 1'b0, 1'b0, -1, 1'b0, 3'd0, 1'b0);
        fill_directed(32'hAD, 32'd3);
        run_cmd(3'd2, 1'b1, 1'b0, -1, 1'b0, 3'd0, 1'b0);

        fill_rand();
        run_cmd(3'd2, 1'b0, 1'b1, -1, 1'b0, 3'd0, 1'b0);
        fill_rand();
        run_cmd(3'd1, 1'b1, 1'b1, -1, 1'b0, 3'd0, 1'b0);

        fill_rand();
        run_cmd(3'd3, 1'b0, 1'b0, 10, 1'b0, 3'd0, 1'b0);
        fill_rand();
        run_cmd(3'd1, 1'b0, 1'b0, -1, 1'b0, 3'd0, 1'b0);

        // Back-to-back: next command held valid during WAIT.
        fill_rand();
        run_cmd(3'd2, 1'b0, 1'b0, -1, 1'b1, 3'd5, 1'b1);
        fill_rand();
        run_cmd(3'd5, 1'b1, 1'b0, -1, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            r_op[i]    = 3'($urandom_range(0, 7));
            r_short[i] = 1'($urandom_range(0, 1));
            r_stall[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            fill_rand();
            run_cmd(r_op[i], r_short[i], r_stall[i], -1, 1'($urandom_range(0, 1)),
                    r_op[i+1], r_short[i+1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
